// File: rtl/clock_pkg.sv
// Shared definitions for the six-digit clock display driver:
// digit count, blink field encodings, capture FSM states and segment table.
package clock_pkg;

    localparam int DIGITS = 6;

    typedef enum logic [1:0] {
        BLINK_NONE = 2'd0,
        BLINK_SEC  = 2'd1,
        BLINK_MIN  = 2'd2,
        BLINK_HR   = 2'd3
    } blink_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CONV_SEC = 3'd1,
        ST_CONV_MIN = 3'd2,
        ST_CONV_HR  = 3'd3,
        ST_COMMIT   = 3'd4
    } conv_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; codes 10-15 are blank.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, SEG_BLANK,  SEG_BLANK,
        SEG_BLANK,  SEG_BLANK,  SEG_BLANK,  SEG_BLANK
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        return SEG_TABLE[bcd];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 6-bit binary to two-digit BCD (shift-add-3): one load cycle,
// then six shift cycles; done_o is high during the final shift cycle.
module bin2bcd_seq (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic [5:0] bin_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic       done_o
);

    logic [13:0] shreg_q, shreg_d;
    logic [2:0]  cnt_q;
    logic        busy_q;
    logic [3:0]  tens_adj, ones_adj;

    always_comb begin
        tens_adj = shreg_q[13:10];
        ones_adj = shreg_q[9:6];
        if (tens_adj >= 4'd5) tens_adj = tens_adj + 4'd3;
        if (ones_adj >= 4'd5) ones_adj = ones_adj + 4'd3;
        // Tens never exceeds 6 for a 6-bit input, so its MSB is safe to drop.
        shreg_d = {tens_adj[2:0], ones_adj, shreg_q[5:0], 1'b0};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (start_i) begin
            shreg_q <= {8'd0, bin_i};
            cnt_q   <= 3'd6;
            busy_q  <= 1'b1;
        end else if (busy_q) begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_q - 3'd1;
            if (cnt_q == 3'd1) busy_q <= 1'b0;
        end
    end

    assign tens_o = shreg_q[13:10];
    assign ones_o = shreg_q[9:6];
    assign done_o = busy_q && (cnt_q == 3'd1);

endmodule

// File: rtl/clock_display_driver.sv
// Multiplexed six-digit HH:MM:SS display driver with atomic time capture
// and per-field blinking.
//   state       | meaning
//   ST_IDLE     | waiting for capture trigger (ms pulse at scan index 5)
//   ST_CONV_SEC | converting snapshot seconds
//   ST_CONV_MIN | converting minutes, storing seconds result
//   ST_CONV_HR  | converting hours, storing minutes result
//   ST_COMMIT   | writing all six BCD digits at once
module clock_display_driver
    import clock_pkg::*;
#(
    parameter int BLINK_HALF_MS = 500
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_ms_pulse,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    input  logic [4:0] i_hr,
    input  logic [1:0] i_blink_sel,
    output logic [5:0] o_an,
    output logic [6:0] o_seg,
    output logic       o_dp
);

    localparam int             BW         = (BLINK_HALF_MS > 1) ? $clog2(BLINK_HALF_MS) : 1;
    localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_HALF_MS - 1);
    localparam logic [2:0]     LAST_DIGIT = 3'(DIGITS - 1);

    conv_state_e              state_q;
    logic                     start_q;
    logic [5:0]               sec_snap_q, min_snap_q;
    logic [4:0]               hr_snap_q;
    logic [3:0]               sec_t_q, sec_o_q, min_t_q, min_o_q;
    logic [DIGITS-1:0][3:0]   digit_q;
    logic [2:0]               scan_q;
    logic [BW-1:0]            blink_cnt_q;
    logic                     blink_ph_q;
    logic [5:0]               an_q, an_d;
    logic [6:0]               seg_q, seg_d;
    logic                     dp_q, dp_d;
    logic [5:0]               conv_bin;
    logic [3:0]               conv_tens, conv_ones;
    logic                     conv_done;
    logic                     trigger;
    logic                     in_field;

    assign trigger = i_ms_pulse && (scan_q == LAST_DIGIT) && (state_q == ST_IDLE);

    always_comb begin
        conv_bin = '0;
        case (state_q)
            ST_CONV_SEC: conv_bin = sec_snap_q;
            ST_CONV_MIN: conv_bin = min_snap_q;
            ST_CONV_HR:  conv_bin = {1'b0, hr_snap_q};
            default:     conv_bin = '0;
        endcase
    end

    bin2bcd_seq u_bin2bcd (
        .clk_i   (i_clk),
        .rst_n_i (i_rstn),
        .start_i (start_q),
        .bin_i   (conv_bin),
        .tens_o  (conv_tens),
        .ones_o  (conv_ones),
        .done_o  (conv_done)
    );

    // The previous field's result is still held by the converter during the
    // first cycle of the next state, while it loads the new field.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            sec_snap_q <= '0;
            min_snap_q <= '0;
            hr_snap_q  <= '0;
            sec_t_q    <= '0;
            sec_o_q    <= '0;
            min_t_q    <= '0;
            min_o_q    <= '0;
            digit_q    <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        sec_snap_q <= i_sec;
                        min_snap_q <= i_min;
                        hr_snap_q  <= i_hr;
                        start_q    <= 1'b1;
                        state_q    <= ST_CONV_SEC;
                    end
                end
                ST_CONV_SEC: begin
                    if (conv_done) begin
                        start_q <= 1'b1;
                        state_q <= ST_CONV_MIN;
                    end
                end
                ST_CONV_MIN: begin
                    if (start_q) {sec_t_q, sec_o_q} <= {conv_tens, conv_ones};
                    if (conv_done) begin
                        start_q <= 1'b1;
                        state_q <= ST_CONV_HR;
                    end
                end
                ST_CONV_HR: begin
                    if (start_q) {min_t_q, min_o_q} <= {conv_tens, conv_ones};
                    if (conv_done) state_q <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    digit_q <= {conv_tens, conv_ones, min_t_q, min_o_q, sec_t_q, sec_o_q};
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            scan_q      <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else if (i_ms_pulse) begin
            scan_q <= (scan_q == LAST_DIGIT) ? 3'd0 : scan_q + 3'd1;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                blink_ph_q  <= ~blink_ph_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BW'(1);
            end
        end
    end

    always_comb begin
        in_field = 1'b0;
        case (blink_sel_e'(i_blink_sel))
            BLINK_SEC: in_field = (scan_q == 3'd0) || (scan_q == 3'd1);
            BLINK_MIN: in_field = (scan_q == 3'd2) || (scan_q == 3'd3);
            BLINK_HR:  in_field = (scan_q == 3'd4) || (scan_q == 3'd5);
            default:   in_field = 1'b0;
        endcase
        an_d  = ~(6'd1 << scan_q);
        seg_d = (blink_ph_q && in_field) ? SEG_BLANK : seg_decode(digit_q[scan_q]);
        dp_d  = ~((scan_q == 3'd4) || (scan_q == 3'd2));
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            an_q  <= 6'h3F;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign o_an  = an_q;
    assign o_seg = seg_q;
    assign o_dp  = dp_q;

endmodule

// File: tb/tb_clock_display_driver.sv
// Self-checking bench for clock_display_driver: a reference model pushes the
// expected per-cycle display output at each ms tick and the sampler pops it.
module tb_clock_display_driver;

    localparam int HALF = 4;
    localparam int GAP  = 30;
    localparam logic [6:0] SEG_REF [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       ms_pulse = 1'b0;
    logic [5:0] sec = '0, min = '0;
    logic [4:0] hr = '0;
    logic [1:0] blink_sel = '0;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int          checks = 0;
    int          errors = 0;
    logic [13:0] sb_q [$];

    int         m_scan, m_bcnt;
    logic       m_ph;
    logic [3:0] m_dig [6];
    logic [3:0] m_new [6];

    clock_display_driver #(.BLINK_HALF_MS(HALF)) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_ms_pulse  (ms_pulse),
        .i_sec       (sec),
        .i_min       (min),
        .i_hr        (hr),
        .i_blink_sel (blink_sel),
        .o_an        (an),
        .o_seg       (seg),
        .o_dp        (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] exp_out(input int scan, input logic [3:0] dg [6],
                                            input logic ph, input logic [1:0] bs);
        logic [5:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int         field;
        e_an       = 6'h3F;
        e_an[scan] = 1'b0;
        e_seg      = SEG_REF[dg[scan]];
        e_dp       = !(scan == 4 || scan == 2);
        field      = scan / 2 + 1;
        if (ph && int'(bs) == field) e_seg = 7'h7F;
        return {e_an, e_seg, e_dp};
    endfunction

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed an/seg/dp=%b/%b/%b expected=%b/%b/%b", tag,
                   obs[13:8], obs[7:1], obs[0], expv[13:8], expv[7:1], expv[0]);
        end
    endtask

    task automatic model_reset();
        m_scan = 0;
        m_bcnt = 0;
        m_ph   = 1'b0;
        for (int i = 0; i < 6; i++) m_dig[i] = 4'd0;
    endtask

    task automatic mid_reset();
        rstn = 1'b0;
        #1;
        check("rst_immediate", {an, seg, dp}, {6'h3F, 7'h7F, 1'b1});
        repeat (3) begin
            @(negedge clk);
            check("rst_hold", {an, seg, dp}, {6'h3F, 7'h7F, 1'b1});
        end
        rstn = 1'b1;
        sb_q.delete();
        model_reset();
    endtask

    // One ms pulse followed by GAP cycles; every cycle is checked.
    task automatic tick(input int chg_at, input logic [5:0] ns, input logic [5:0] nm,
                        input logic [4:0] nh, input int rst_at);
        int   old_scan;
        logic old_ph;
        @(negedge clk);
        old_scan = m_scan;
        old_ph   = m_ph;
        for (int i = 0; i < 6; i++) m_new[i] = m_dig[i];
        if (m_scan == 5) begin
            m_new[5] = 4'(int'(hr) / 10);
            m_new[4] = 4'(int'(hr) % 10);
            m_new[3] = 4'(int'(min) / 10);
            m_new[2] = 4'(int'(min) % 10);
            m_new[1] = 4'(int'(sec) / 10);
            m_new[0] = 4'(int'(sec) % 10);
        end
        m_scan = (m_scan + 1) % 6;
        if (m_bcnt == HALF - 1) begin
            m_bcnt = 0;
            m_ph   = ~m_ph;
        end else begin
            m_bcnt++;
        end
        sb_q.push_back(exp_out(old_scan, m_dig, old_ph, blink_sel));
        for (int k = 2; k <= GAP; k++) begin
            if (k >= 24) sb_q.push_back(exp_out(m_scan, m_new, m_ph, blink_sel));
            else         sb_q.push_back(exp_out(m_scan, m_dig, m_ph, blink_sel));
        end
        for (int i = 0; i < 6; i++) m_dig[i] = m_new[i];
        ms_pulse = 1'b1;
        for (int k = 1; k <= GAP; k++) begin
            @(negedge clk);
            if (k == 1) ms_pulse = 1'b0;
            if (k == chg_at) begin
                sec = ns;
                min = nm;
                hr  = nh;
            end
            if (k == rst_at) begin
                mid_reset();
                return;
            end
            check("scan_cycle", {an, seg, dp}, sb_q.pop_front());
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("in_reset", {an, seg, dp}, {6'h3F, 7'h7F, 1'b1});
        rstn = 1'b1;
        @(negedge clk);
        check("reset_release", {an, seg, dp}, {6'b111110, 7'b1000000, 1'b1});

        hr = 5'd23; min = 6'd45; sec = 6'd7;
        repeat (12) tick(-1, '0, '0, '0, -1);

        sec = 6'd63; min = 6'd60; hr = 5'd31;
        repeat (12) tick(-1, '0, '0, '0, -1);

        sec = 6'd56; min = 6'd34; hr = 5'd12;
        while (m_scan != 5) tick(-1, '0, '0, '0, -1);
        tick(10, 6'd0, 6'd35, 5'd12, -1);
        repeat (12) tick(-1, '0, '0, '0, -1);

        blink_sel = 2'd2;
        repeat (16) tick(-1, '0, '0, '0, -1);
        blink_sel = 2'd0;

        while (m_scan != 5) tick(-1, '0, '0, '0, -1);
        tick(-1, '0, '0, '0, 12);
        @(negedge clk);
        check("post_mid_reset", {an, seg, dp}, {6'b111110, 7'b1000000, 1'b1});
        repeat (12) tick(-1, '0, '0, '0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
